// File: rtl/keypad_pkg.sv
// Shared types for the CHIP-8 keypad controller.
// Key indices follow CHIP-8 key order (0x0..0xF).
package keypad_pkg;

  localparam int NUM_KEYS = 16;

  typedef logic [3:0] key_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HELD
  } wait_state_t;

  function automatic key_idx_t lowest_key(
    input logic [NUM_KEYS-1:0] v
  );
    key_idx_t k;
    k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) k = key_idx_t'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: state follows raw after DEBOUNCE_CYCLES
// consecutive differing cycles; rise/fall pulse for one cycle.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_in,
  output logic state_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = raw_in != r_state;
  assign w_flip = w_diff && (r_cnt == LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_flip && raw_in;
      r_fall <= w_flip && !raw_in;
      if (!w_diff || w_flip) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
      if (w_flip) r_state <= raw_in;
    end
  end

  assign state_out = r_state;
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;

endmodule

// File: rtl/keypad_ctrl.sv
// Keypad front end for the CHIP-8 core: per-key debounce,
// registered key query, and the FX0A wait-for-key sequencer.
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] keymap_in,
  output logic [15:0] keys_db_out,
  input  logic [3:0]  query_key_in,
  output logic        query_pressed_out,
  input  logic        wait_req_in,
  input  logic        cancel_in,
  output logic        wait_busy_out,
  output logic        wait_done_out,
  output logic [3:0]  wait_key_out
);

  logic [NUM_KEYS-1:0] w_db;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_fall;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .raw_in   (keymap_in[g]),
      .state_out(w_db[g]),
      .rise_out (w_rise[g]),
      .fall_out (w_fall[g])
    );
  end

  wait_state_t r_state;
  wait_state_t w_next;
  key_idx_t    r_cap;
  key_idx_t    r_key;
  logic        r_done;
  logic        r_busy;
  logic        r_query;
  logic        w_capture;
  logic        w_done;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (wait_req_in) w_next = ARMED;
      ARMED: begin
        if (cancel_in)    w_next = IDLE;
        else if (|w_rise) w_next = HELD;
      end
      HELD: begin
        if (cancel_in)           w_next = IDLE;
        else if (w_fall[r_cap])  w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Cancel takes priority over both capture and completion.
  always_comb begin
    w_capture = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      ARMED:   w_capture = !cancel_in && (|w_rise);
      HELD:    w_done    = !cancel_in && w_fall[r_cap];
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_cap   <= '0;
      r_key   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_query <= 1'b0;
    end else begin
      if (w_capture) r_cap <= lowest_key(w_rise);
      if (w_done)    r_key <= r_cap;
      r_done  <= w_done;
      r_busy  <= w_next != IDLE;
      r_query <= w_db[query_key_in];
    end
  end

  assign keys_db_out       = w_db;
  assign query_pressed_out = r_query;
  assign wait_busy_out     = r_busy;
  assign wait_done_out     = r_done;
  assign wait_key_out      = r_key;

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed bench for keypad_ctrl with a done-event scoreboard.
`timescale 1ns/1ps
module tb_keypad_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] keymap;
  logic [15:0] keys_db;
  logic [3:0]  qkey;
  logic        qpress;
  logic        req;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [3:0]  wkey;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  keypad_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .keymap_in        (keymap),
    .keys_db_out      (keys_db),
    .query_key_in     (qkey),
    .query_pressed_out(qpress),
    .wait_req_in      (req),
    .cancel_in        (cancel),
    .wait_busy_out    (busy),
    .wait_done_out    (done),
    .wait_key_out     (wkey)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected key.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got key %0h want no done", wkey);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (wkey !== e) begin
          bad++;
          $display("FAIL done_key: got %0h want %0h", wkey, e);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    keymap = 16'hFFFF;
    qkey   = 4'h0;
    req    = 1'b0;
    cancel = 1'b0;
    tick(2);
    chk("rst_db", keys_db, 16'h0);
    chk("rst_q", qpress, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_key", wkey, 4'h0);

    rst_n = 1'b1;
    tick(3);
    chk("db_after3", keys_db, 16'h0);
    tick(1);
    chk("db_after4", keys_db, 16'hFFFF);
    keymap = 16'h0;
    tick(5);
    chk("db_clear", keys_db, 16'h0);

    // Bounce on key 5
    keymap[5] = 1'b1; tick(3);
    keymap[5] = 1'b0; tick(1);
    chk("bounce_glitch", keys_db[5], 1'b0);
    keymap[5] = 1'b1; tick(3);
    chk("bounce_run3", keys_db[5], 1'b0);
    tick(1);
    chk("bounce_run4", keys_db, 16'h0020);
    keymap[5] = 1'b0; tick(5);

    // Query
    keymap[10] = 1'b1; tick(4);
    chk("q_db", keys_db, 16'h0400);
    qkey = 4'hA; tick(1);
    chk("q_a", qpress, 1'b1);
    qkey = 4'hB; tick(1);
    chk("q_b", qpress, 1'b0);
    keymap[10] = 1'b0; tick(5);

    // Wait with a pre-held key 7
    keymap[7] = 1'b1; tick(5);
    req = 1'b1; tick(1); req = 1'b0;
    chk("w_busy", busy, 1'b1);
    tick(3);
    chk("w_nocap", busy, 1'b1);
    keymap[3] = 1'b1; tick(5);
    chk("w_held", busy, 1'b1);
    exp_q.push_back(4'h3);
    keymap[3] = 1'b0; tick(4);
    chk("w_busy_pre", busy, 1'b1);
    tick(1);
    chk("w_done", done, 1'b1);
    chk("w_busy_end", busy, 1'b0);
    chk("w_key", wkey, 4'h3);
    tick(1);
    chk("w_done_1cyc", done, 1'b0);
    keymap[7] = 1'b0; tick(5);

    // Priority: 9 and 2 together
    req = 1'b1; tick(1); req = 1'b0;
    keymap[9] = 1'b1; keymap[2] = 1'b1; tick(5);
    keymap[9] = 1'b0; tick(6);
    chk("p_busy", busy, 1'b1);
    exp_q.push_back(4'h2);
    keymap[2] = 1'b0; tick(6);
    chk("p_busy_end", busy, 1'b0);
    chk("p_key", wkey, 4'h2);

    // Cancel coincident with the completing release
    req = 1'b1; tick(1); req = 1'b0;
    keymap[4] = 1'b1; tick(5);
    chk("c_held", busy, 1'b1);
    keymap[4] = 1'b0; tick(4);
    cancel = 1'b1; tick(1); cancel = 1'b0;
    chk("c_busy", busy, 1'b0);
    chk("c_nodone", done, 1'b0);
    tick(3);
    chk("c_key", wkey, 4'h2);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
